// File: rtl/ram_access_arbiter.sv
// Two-port round-robin arbiter that sequences accesses to a single-port synchronous RAM.
// Each accepted request takes three cycles: accept (IDLE), drive the RAM (ISSUE), respond (RESP).
module ram_access_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [DATA_W-1:0] ram_dataIN,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_readWrite,
    input  logic [DATA_W-1:0] ram_dataOUT,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    // Handshake: a request transfers on a cycle where reqN_valid && reqN_ready.
    // Requesters hold valid and fields stable until ready; responses cannot be stalled.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic                lat_id;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                grant0;
    logic                grant1;

    // On contention, the port that did not win last time gets the grant.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign busy        = (state != IDLE);
    assign fsm_state   = state;
    assign ram_address = lat_addr;
    assign ram_dataIN  = lat_wdata;

    always_comb begin
        state_nxt     = state;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        rsp0_valid    = 1'b0;
        rsp1_valid    = 1'b0;
        rsp0_rdata    = '0;
        rsp1_rdata    = '0;
        ram_readWrite = 1'b1;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_nxt = ISSUE;
            end
            ISSUE: begin
                ram_readWrite = ~lat_we;
                state_nxt     = RESP;
            end
            RESP: begin
                if (lat_id) begin
                    rsp1_valid = 1'b1;
                    rsp1_rdata = lat_we ? '0 : ram_dataOUT;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_rdata = lat_we ? '0 : ram_dataOUT;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset aborts any write being committed on this edge and hides in-flight responses.
        if (reset) begin
            ram_readWrite = 1'b1;
            req0_ready    = 1'b0;
            req1_ready    = 1'b0;
            rsp0_valid    = 1'b0;
            rsp1_valid    = 1'b0;
            rsp0_rdata    = '0;
            rsp1_rdata    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (grant0 || grant1)) begin
                lat_id     <= grant1;
                last_grant <= grant1;
                lat_we     <= grant1 ? req1_we    : req0_we;
                lat_addr   <= grant1 ? req1_addr  : req0_addr;
                lat_wdata  <= grant1 ? req1_wdata : req0_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural single-port RAM behind it.
// Inputs change on the falling edge; outputs are sampled shortly after.
module tb_ram_access_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_we;
    logic [4:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [4:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic [31:0] ram_dataIN;
    logic [4:0]  ram_address;
    logic        ram_readWrite;
    logic [31:0] ram_dataOUT;
    logic        busy;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;
    int waited;

    logic [31:0] mem [0:31];

    ram_access_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_dataIN(ram_dataIN), .ram_address(ram_address),
        .ram_readWrite(ram_readWrite), .ram_dataOUT(ram_dataOUT),
        .busy(busy), .fsm_state(fsm_state)
    );

    // Clock and RAM model: writes when readWrite=0, registered read otherwise.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        ram_dataOUT = '0;
    end

    always @(posedge clk) begin
        if (!ram_readWrite) mem[ram_address] <= ram_dataIN;
        else                ram_dataOUT      <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ready must never be high for both ports, nor outside IDLE.
    always @(negedge clk) begin
        #2;
        check("rdy_excl", {30'd0, req0_ready & req1_ready, (req0_ready | req1_ready) & busy}, 32'd0);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction from the current IDLE negedge; returns at the following IDLE negedge.
    task automatic txn(input int port, input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       output int wait_cycles);
        logic rdy;
        wait_cycles = 0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end
        #1;
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && wait_cycles < 8) begin
            step();
            #1;
            wait_cycles++;
            rdy = (port == 0) ? req0_ready : req1_ready;
        end
        check("accept", {31'd0, rdy}, 32'd1);
        check("rw_idle", {31'd0, ram_readWrite}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("issue_state", {30'd0, fsm_state}, 32'd1);
        check("issue_rw", {31'd0, ram_readWrite}, {31'd0, ~we});
        check("issue_addr", {27'd0, ram_address}, {27'd0, addr});
        if (we) check("issue_din", ram_dataIN, wdata);
        step();
        #1;
        check("resp_rw", {31'd0, ram_readWrite}, 32'd1);
        check("rsp_win_valid", {31'd0, (port == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
        check("rsp_other_valid", {31'd0, (port == 0) ? rsp1_valid : rsp0_valid}, 32'd0);
        check("rsp_rdata", (port == 0) ? rsp0_rdata : rsp1_rdata, we ? 32'd0 : exp_rdata);
        check("rsp_other_rdata", (port == 0) ? rsp1_rdata : rsp0_rdata, 32'd0);
        step();
    endtask

    initial begin
        logic [31:0] exp_data;
        int winner;
        reset = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        @(negedge clk);
        step();
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rw", {31'd0, ram_readWrite}, 32'd1);
        check("rst_addr", {27'd0, ram_address}, 32'd0);
        check("rst_din", ram_dataIN, 32'd0);
        check("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

        // Basic write then read across ports.
        txn(0, 1'b1, 5'd5, 32'hDEADBEEF, 32'd0, waited);
        #1;
        check("after_wr_busy", {31'd0, busy}, 32'd0);
        txn(1, 1'b0, 5'd5, 32'd0, 32'hDEADBEEF, waited);

        // Preload for contention; port1 ends as last grant, so port0 wins next.
        txn(0, 1'b1, 5'd1, 32'h11, 32'd0, waited);
        txn(1, 1'b1, 5'd2, 32'h22, 32'd0, waited);

        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 5'd2;
        for (int k = 0; k < 4; k++) begin
            winner = k % 2;
            exp_data = (winner == 0) ? 32'h11 : 32'h22;
            #1;
            check("cont_ready0", {31'd0, req0_ready}, (winner == 0) ? 32'd1 : 32'd0);
            check("cont_ready1", {31'd0, req1_ready}, (winner == 1) ? 32'd1 : 32'd0);
            step();
            step();
            #1;
            check("cont_rsp0_valid", {31'd0, rsp0_valid}, (winner == 0) ? 32'd1 : 32'd0);
            check("cont_rsp1_valid", {31'd0, rsp1_valid}, (winner == 1) ? 32'd1 : 32'd0);
            check("cont_rdata", (winner == 0) ? rsp0_rdata : rsp1_rdata, exp_data);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Port1 alone, back to back: each accepted with no waiting.
        txn(1, 1'b0, 5'd2, 32'd0, 32'h22, waited);
        check("b2b_wait0", waited, 32'd0);
        txn(1, 1'b0, 5'd1, 32'd0, 32'h11, waited);
        check("b2b_wait1", waited, 32'd0);
        txn(1, 1'b0, 5'd5, 32'd0, 32'hDEADBEEF, waited);
        check("b2b_wait2", waited, 32'd0);

        // Reset during ISSUE of a write aborts it.
        txn(0, 1'b1, 5'd7, 32'h12345678, 32'd0, waited);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 5'd7; req0_wdata = 32'hA5A5A5A5;
        #1;
        check("abort_accept", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_rw", {31'd0, ram_readWrite}, 32'd1);
        step();
        #1;
        check("abort_rsp_in_rst", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        reset = 1'b0;
        step();
        #1;
        check("abort_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        txn(0, 1'b0, 5'd7, 32'd0, 32'h12345678, waited);

        // Top address.
        txn(0, 1'b1, 5'd31, 32'hFFFFFFFF, 32'd0, waited);
        txn(1, 1'b0, 5'd31, 32'd0, 32'hFFFFFFFF, waited);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
